// File: rtl/hps_pkg.sv
// Definitions shared by the HPS terminal and the instruction FIFO.
// An instruction packs a 32-bit data word above a 16-bit address.
package hps_pkg;

  localparam int INSTR_W  = 64;
  localparam int DATA_MSB = 63;
  localparam int DATA_LSB = 32;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  // Source of the next head-of-queue value presented on the read port.
  typedef enum logic [1:0] {
    HEAD_HOLD   = 2'd0,
    HEAD_BYPASS = 2'd1,
    HEAD_MEM    = 2'd2
  } head_sel_t;

  function automatic instr_t make_instr(input logic [31:0] data, input logic [15:0] addr);
    instr_t instr;
    instr                    = '0;
    instr[DATA_MSB:DATA_LSB] = data;
    instr[ADDR_MSB:ADDR_LSB] = addr;
    return instr;
  endfunction

endpackage

// File: rtl/strobe_rise.sv
// One-bit rising-edge detector for level strobes that last several cycles.
// The delayed copy clears on reset, so a strobe still high at release counts as a new edge.
module strobe_rise (
  input  logic s_clk,
  input  logic s_reset,
  input  logic strobe,
  output logic rise
);

  logic strobe_q_reg;

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      strobe_q_reg <= 1'b0;
    end else begin
      strobe_q_reg <= strobe;
    end
  end

  assign rise = strobe & ~strobe_q_reg;

endmodule

// File: rtl/hps_instr_fifo.sv
// Instruction FIFO between the HPS terminal and the core-side instruction bus.
// Edge-qualified push/pop strobes, registered first-word-fall-through head.
module hps_instr_fifo
  import hps_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               s_clk,
  input  logic               s_reset,
  input  logic               clear,
  input  logic               wr,
  input  logic [INSTR_W-1:0] wr_instruction,
  output logic               wr_busy,
  input  logic               rd,
  output logic               rd_valid,
  output logic [INSTR_W-1:0] rd_instruction,
  output logic [AW:0]        level,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0] strobe_vec;
  logic [1:0] rise_vec;
  logic       push;
  logic       pop;

  assign strobe_vec = {rd, wr};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rise
    strobe_rise u_rise (
      .s_clk   (s_clk),
      .s_reset (s_reset),
      .strobe  (strobe_vec[gi]),
      .rise    (rise_vec[gi])
    );
  end

  assign push = rise_vec[0];
  assign pop  = rise_vec[1];

  instr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          rd_valid_reg;
  logic          wr_busy_reg;
  logic          overflow_reg;
  logic          underflow_reg;
  instr_t        rd_instruction_reg;

  logic      is_full;
  logic      is_empty;
  logic      do_push;
  logic      do_pop;
  logic      ovf_set;
  logic      unf_set;
  head_sel_t head_sel;

  assign is_full    = (level_reg == LVL_FULL);
  assign is_empty   = (level_reg == '0);
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    level_next = level_reg;
    head_sel   = HEAD_HOLD;

    if (clear) begin
      level_next = '0;
    end else begin
      // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
      do_push = push & (~is_full | pop);
      do_pop  = pop & ~is_empty;
      ovf_set = push & is_full & ~pop;
      unf_set = pop & is_empty;

      if (do_push && !do_pop) begin
        level_next = level_reg + LVL_ONE;
      end else if (!do_push && do_pop) begin
        level_next = level_reg - LVL_ONE;
      end

      // With one entry left, the next head is the word being written right now.
      if (do_push && is_empty) begin
        head_sel = HEAD_BYPASS;
      end else if (do_pop && level_next != '0) begin
        head_sel = (level_reg == LVL_ONE) ? HEAD_BYPASS : HEAD_MEM;
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_instruction;
    end
  end

  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      level_reg          <= '0;
      rd_valid_reg       <= 1'b0;
      wr_busy_reg        <= 1'b0;
      overflow_reg       <= 1'b0;
      underflow_reg      <= 1'b0;
      rd_instruction_reg <= '0;
    end else begin
      level_reg    <= level_next;
      rd_valid_reg <= (level_next != '0);
      wr_busy_reg  <= (level_next == LVL_FULL) | push;

      if (clear) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
        if (ovf_set) overflow_reg <= 1'b1;
        if (unf_set) underflow_reg <= 1'b1;
      end

      case (head_sel)
        HEAD_BYPASS: rd_instruction_reg <= wr_instruction;
        HEAD_MEM:    rd_instruction_reg <= mem[rd_ptr_inc];
        default:     rd_instruction_reg <= rd_instruction_reg;
      endcase
    end
  end

  assign wr_busy        = wr_busy_reg;
  assign rd_valid       = rd_valid_reg;
  assign rd_instruction = rd_instruction_reg;
  assign level          = level_reg;
  assign overflow       = overflow_reg;
  assign underflow      = underflow_reg;

endmodule

// File: tb/tb_hps_instr_fifo.sv
// Randomised scoreboard bench for hps_instr_fifo against a queue-based reference model.
module tb_hps_instr_fifo;
  import hps_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          s_clk;
  logic          s_reset;
  logic          clr;
  logic          wr;
  logic [63:0]   wdata;
  logic          wr_busy;
  logic          rd;
  logic          rd_valid;
  logic [63:0]   rd_instruction;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  hps_instr_fifo #(.DEPTH(DEPTH)) dut (
    .s_clk          (s_clk),
    .s_reset        (s_reset),
    .clear          (clr),
    .wr             (wr),
    .wr_instruction (wdata),
    .wr_busy        (wr_busy),
    .rd             (rd),
    .rd_valid       (rd_valid),
    .rd_instruction (rd_instruction),
    .level          (level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  int checks = 0;
  int errors = 0;
  int pops_seen = 0;

  // Reference model: FIFO contents, sticky flags and previous strobe levels.
  logic [63:0] ref_q[$];
  logic [63:0] exp_pop_q[$];
  logic [63:0] got_pop_q[$];
  bit ovf_m, unf_m, busy_m, wr_prev, rd_prev;
  bit mon_en = 0;
  bit mon_rd_prev = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    ovf_m = 0; unf_m = 0; busy_m = 0; wr_prev = 0; rd_prev = 0;
  endtask

  task automatic model_update();
    bit p, q;
    if (s_reset) begin
      model_reset();
      return;
    end
    p = wr && !wr_prev;
    q = rd && !rd_prev;
    wr_prev = wr;
    rd_prev = rd;
    if (clr) begin
      ref_q.delete();
      ovf_m = 0;
      unf_m = 0;
    end else begin
      if (q) begin
        if (ref_q.size() == 0) unf_m = 1;
        else exp_pop_q.push_back(ref_q.pop_front());
      end
      if (p) begin
        if (ref_q.size() < DEPTH) ref_q.push_back(wdata);
        else ovf_m = 1;
      end
    end
    busy_m = (ref_q.size() == DEPTH) || p;
  endtask

  task automatic tick();
    @(posedge s_clk);
    model_update();
    #1;
  endtask

  task automatic push_op(input logic [63:0] d, input int hold);
    wr = 1; wdata = d;
    repeat (hold) tick();
    wr = 0;
    tick();
  endtask

  task automatic pop_op(input int hold);
    rd = 1;
    repeat (hold) tick();
    rd = 0;
    tick();
  endtask

  task automatic both_op(input logic [63:0] d);
    wr = 1; rd = 1; wdata = d;
    tick(); tick();
    wr = 0; rd = 0;
    tick();
  endtask

  task automatic do_clear();
    clr = 1;
    tick();
    clr = 0;
    tick();
  endtask

  // Monitor: compares DUT state with the model every cycle and matches popped words.
  always @(negedge s_clk) begin
    if (mon_en) begin
      chk("level", 64'(level), 64'(ref_q.size()));
      chk("rd_valid", 64'(rd_valid), 64'(ref_q.size() != 0));
      if (ref_q.size() != 0) chk("head", rd_instruction, ref_q[0]);
      chk("overflow", 64'(overflow), 64'(ovf_m));
      chk("underflow", 64'(underflow), 64'(unf_m));
      chk("wr_busy", 64'(wr_busy), 64'(busy_m));
      if (rd && !mon_rd_prev && rd_valid && !clr && !s_reset)
        got_pop_q.push_back(rd_instruction);
      mon_rd_prev = s_reset ? 1'b0 : rd;
      while (exp_pop_q.size() != 0 && got_pop_q.size() != 0) begin
        logic [63:0] e, g;
        e = exp_pop_q.pop_front();
        g = got_pop_q.pop_front();
        pops_seen++;
        $display("pop %0d: data %h (expected %h)", pops_seen, g, e);
        chk("popped_word", g, e);
      end
    end
  end

  initial begin
    s_reset = 1; clr = 0; wr = 0; rd = 0; wdata = '0;
    model_reset();
    repeat (2) tick();
    chk("rst_wr_busy", 64'(wr_busy), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_instr", rd_instruction, 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    s_reset = 0;
    mon_en = 1;
    tick();

    // Single push then pop, one-cycle latency.
    wr = 1; wdata = 64'hDEADBEEF_0000_0064;
    tick();
    chk("single_valid", 64'(rd_valid), 64'd1);
    chk("single_instr", rd_instruction, 64'hDEADBEEF_0000_0064);
    chk("single_level", 64'(level), 64'd1);
    tick();
    wr = 0;
    tick();
    pop_op(2);
    chk("single_pop_level", 64'(level), 64'd0);
    chk("single_pop_valid", 64'(rd_valid), 64'd0);
    chk("single_pop_unf", 64'(underflow), 64'd0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) push_op(64'(i), 1);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_busy", 64'(wr_busy), 64'd1);
    push_op(64'h77, 1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    for (int i = 0; i < 16; i++) pop_op(1);
    do_clear();
    chk("clear_ovf", 64'(overflow), 64'd0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) push_op(make_instr(32'h1000 + i, 16'(i)), 1);
    for (int i = 0; i < 10; i++) pop_op(1);
    for (int i = 0; i < 12; i++) push_op(make_instr(32'h2000 + i, 16'(i)), 2);
    for (int i = 0; i < 12; i++) pop_op(2);
    chk("wrap_level", 64'(level), 64'd0);
    chk("wrap_ovf", 64'(overflow), 64'd0);
    chk("wrap_unf", 64'(underflow), 64'd0);

    // Simultaneous push and pop while full, then while empty.
    for (int i = 0; i < 16; i++) push_op(64'(100 + i), 1);
    both_op(64'd999);
    chk("full_both_level", 64'(level), 64'd16);
    chk("full_both_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) pop_op(1);
    both_op(64'hABCD);
    chk("empty_both_level", 64'(level), 64'd1);
    chk("empty_both_unf", 64'(underflow), 64'd1);
    pop_op(1);
    do_clear();

    // Long rd strobe gives a single pop.
    for (int i = 0; i < 3; i++) push_op(64'(300 + i), 1);
    pop_op(5);
    chk("long_rd_level", 64'(level), 64'd2);
    pop_op(1); pop_op(1);

    // Asynchronous reset mid-stream; wr held through release gives one push.
    for (int i = 0; i < 5; i++) push_op(64'(500 + i), 1);
    chk("pre_reset_level", 64'(level), 64'd5);
    #2;
    s_reset = 1;
    model_reset();
    #1;
    chk("async_level", 64'(level), 64'd0);
    chk("async_valid", 64'(rd_valid), 64'd0);
    chk("async_instr", rd_instruction, 64'd0);
    chk("async_busy", 64'(wr_busy), 64'd0);
    wr = 1; wdata = 64'h5555;
    tick();
    s_reset = 0;
    tick();
    chk("release_push_level", 64'(level), 64'd1);
    chk("release_push_instr", rd_instruction, 64'h5555);
    wr = 0;
    tick();
    pop_op(1);

    // Clear coincident with a push wins; flags cleared.
    pop_op(1);
    chk("pre_clear_unf", 64'(underflow), 64'd1);
    wr = 1; clr = 1; wdata = 64'h6666;
    tick();
    chk("clear_push_level", 64'(level), 64'd0);
    chk("clear_push_unf", 64'(underflow), 64'd0);
    chk("clear_push_ovf", 64'(overflow), 64'd0);
    clr = 0;
    tick();
    chk("clear_hold_level", 64'(level), 64'd0);
    wr = 0;
    tick();

    // Randomised phases with different push/pop densities.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 75 : (ph == 1) ? 30 : (ph == 2) ? 50 : 65;
      pr = (ph == 0) ? 25 : (ph == 1) ? 70 : (ph == 2) ? 50 : 65;
      for (int c = 0; c < 800; c++) begin
        wr    = ($urandom_range(0, 99) < pw);
        rd    = ($urandom_range(0, 99) < pr);
        wdata = make_instr($urandom, 16'($urandom));
        clr   = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    wr = 0; rd = 0; clr = 0;
    repeat (3) tick();
    @(negedge s_clk);
    #1;
    chk("pending_expected_pops", 64'(exp_pop_q.size()), 64'd0);
    chk("pending_observed_pops", 64'(got_pop_q.size()), 64'd0);
    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_instr_fifo.md
# hps_instr_fifo

Queues 64-bit instructions between the HPS terminal and the core-side instruction bus. Its write side consumes the terminal's `wr`/`wr_instruction` strobe, with `wr_busy` as back-pressure. Its read side presents the terminal's readback port (`rd_valid`/`rd_instruction`, with `rd` as acknowledge). Both strobes are level pulses lasting two or more cycles, so each is edge-qualified: exactly one push or pop occurs per strobe.

## Interface
- `DEPTH`, default 16: entries; power of two, ≥4.
- `AW`, default $clog2(DEPTH): pointer width.
- `s_clk`  in  1  sole clock.
- `s_reset`  in  1  reset; asynchronous, active-high.
- `clear`  in  1  synchronous flush, one cycle.
- `wr`  in  1  push strobe; level pulse ≥1 cycle; rising edge = one push.
- `wr_instruction`  in  64  instruction `{data[63:32], 16'd0, addr[15:0]}`; sampled on the cycle `wr` rises.
- `wr_busy`  out  1  registered; high when full or a push is being absorbed.
- `rd`  in  1  pop acknowledge; level pulse ≥1 cycle; rising edge = one pop.
- `rd_valid`  out  1  registered; head entry present.
- `rd_instruction`  out  64  registered head entry; stable while `rd_valid` is high and no pop occurs.
- `level`  out  AW+1  registered occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a pop occurred while empty.

## Operation
- Edge detect:
  - `push = wr & ~wr_q`.
  - `pop = rd & ~rd_q`.
  - `wr_q` and `rd_q` are registered copies of the inputs; both reset to 0.
- Storage: DEPTH×64 array with a write pointer and a read pointer, each AW bits and wrapping modulo DEPTH. `level` is tracked separately.
- Push with `level < DEPTH`: write the array at the write pointer, increment the write pointer, level+1.
- Push with `level == DEPTH` and no pop: entry dropped, `overflow` set, pointers unchanged.
- Push and pop in the same cycle while full: both performed, level unchanged.
- Push and pop in the same cycle while non-empty and not full: both performed, level unchanged.
- Push and pop in the same cycle while empty: push accepted, pop ignored, `underflow` set.
- Pop while empty: ignored, `underflow` set.
- `rd_instruction`: first-word-fall-through register.
  - Loads the new head on the cycle after a push into an empty FIFO.
  - Loads the new head on the cycle after a pop that leaves the FIFO non-empty.
  - Otherwise holds its value.
- `rd_valid = (level != 0)`, registered alongside `rd_instruction`.
- `wr_busy`: next value is `(level_next == DEPTH) | push`. It therefore stays high during the cycle after any accepted push, which covers the terminal's check-then-strobe latency.
- `clear`: zeros the pointers, `level`, `rd_valid`, `overflow` and `underflow`. Array contents and `rd_instruction` are don't-care. `clear` has priority over a push or pop in the same cycle.
- The instruction is passed through unmodified; the block does not interpret the data or address fields.

## Timing
- Reset values:
  - `wr_busy` 0, `rd_valid` 0, `rd_instruction` 0, `level` 0, `overflow` 0, `underflow` 0.
  - Pointers 0, `wr_q` 0, `rd_q` 0.
- Push latency into an empty FIFO: `wr` rises on cycle N → `rd_valid` = 1 and `rd_instruction` valid on N+1.
- Pop latency: `rd` rises on cycle N → `level` is decremented at N+1, and `rd_instruction` shows the next entry at N+1 (`rd_valid` = 0 if the FIFO is now empty).
- A strobe held high for k cycles produces exactly one operation. A new operation needs `wr` (or `rd`) low for ≥1 cycle first.
- Maximum throughput: one push every 2 cycles and one pop every 2 cycles, concurrently.
- Reset asserted mid-strobe: state returns to the reset values. If the strobe is still high at reset release, `wr_q`/`rd_q` = 0, so the next cycle counts it as a new edge and performs one operation.

## Structure
- Shared package `hps_pkg`:
  - `INSTR_W` = 64.
  - Field constants `DATA_MSB` = 63, `DATA_LSB` = 32, `ADDR_MSB` = 15, `ADDR_LSB` = 0.
  - Typedef `instr_t`.
  - The HPS terminal uses the same definitions.
- Sub-module `strobe_rise`: one-bit rising-edge detector with asynchronous active-high reset. It is instantiated twice, once for `wr` and once for `rd`.

## Test plan
- Single push then pop:
  - Push 0xDEADBEEF_0000_0064 (`wr` high 2 cycles) → `rd_valid` = 1 and `rd_instruction` = 0xDEADBEEF_0000_0064 one cycle later, `level` = 1.
  - Then `rd` high 2 cycles → `level` = 0, `rd_valid` = 0, no `underflow`.
- Fill and overflow (DEPTH=16):
  - 16 pushes with data 0..15 → `level` = 16, `wr_busy` = 1.
  - 17th push → `overflow` = 1, `level` = 16.
  - 16 pops return data 0..15 in order.
- Wrap-around: 10 pushes, 10 pops, then 12 pushes and 12 pops → order preserved, `level` returns to 0, no flags set.
- Push and pop edges on the same cycle:
  - While full → `level` stays 16 and the popped entry is the oldest.
  - While empty → `level` = 1, `underflow` = 1.
- Pop with `rd` held high for 5 cycles while `level` = 3 → `level` = 2 (one pop only).
- Reset and clear:
  - Asynchronous `s_reset` asserted mid-stream with `level` = 5 → all outputs take their reset values immediately.
  - `clear` coincident with a push → `level` = 0 and flags = 0 on the next cycle.
